// File: rtl/rshift_seq_pkg.sv
// Shared definitions for the multi-cycle right shifter.
// Optional sign-fill support is enabled with the RSHIFT_ARITH_EN macro.
package rshift_seq_pkg;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_SHIFT = 2'd1,
        RS_DONE  = 2'd2
    } rs_state_e;

    localparam int unsigned RS_AMT_W    = 4;
    localparam int unsigned RS_STEP_BIG = 4;

    // Number of shift steps for a given amount: big steps first, then single bits.
    function automatic int unsigned rs_step_count(input logic [RS_AMT_W-1:0] amt);
        return int'(amt) / RS_STEP_BIG + int'(amt) % RS_STEP_BIG;
    endfunction

endpackage

// File: rtl/rshift_step.sv
// One combinational right-shift step: by RS_STEP_BIG bits or by one bit,
// with the vacated positions filled from a single fill bit.
module rshift_step
    import rshift_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic             big,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        if (big) begin
            result = {{RS_STEP_BIG{fill}}, value[WIDTH-1:RS_STEP_BIG]};
        end else begin
            result = {fill, value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/rshift_seq.sv
// Multi-cycle right shifter: 4 bits per step while >=4 remain, else 1 bit.
// Define RSHIFT_ARITH_EN to honour the arith input (sign fill).
module rshift_seq
    import rshift_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    in,
    input  logic [RS_AMT_W-1:0] amt,
    input  logic                arith,
    output logic [WIDTH-1:0]    out,
    output logic                busy,
    output logic                done
);

    rs_state_e           state_q, state_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [RS_AMT_W-1:0] rem_q, rem_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                step_big;
    logic                step_fill;
    logic [WIDTH-1:0]    step_out;

`ifdef RSHIFT_ARITH_EN
    logic fill_q, fill_d;

    assign step_fill = fill_q;
`else
    logic unused_arith;

    assign unused_arith = arith;
    assign step_fill    = 1'b0;
`endif

    assign step_big = (rem_q >= RS_AMT_W'(RS_STEP_BIG));

    rshift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value  (out_q),
        .big    (step_big),
        .fill   (step_fill),
        .result (step_out)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
`ifdef RSHIFT_ARITH_EN
        fill_d  = fill_q;
`endif
        case (state_q)
            RS_IDLE: begin
                if (start) begin
                    out_d   = in;
                    rem_d   = amt;
`ifdef RSHIFT_ARITH_EN
                    fill_d  = arith & in[WIDTH-1];
`endif
                    state_d = (amt == '0) ? RS_DONE : RS_SHIFT;
                end
            end
            RS_SHIFT: begin
                out_d = step_out;
                rem_d = step_big ? rem_q - RS_AMT_W'(RS_STEP_BIG) : rem_q - 1'b1;
                if (rem_d == '0) begin
                    state_d = RS_DONE;
                end
            end
            RS_DONE: begin
                state_d = RS_IDLE;
            end
            default: begin
                state_d = RS_IDLE;
            end
        endcase
        // busy follows the next state so it is high in the cycle after acceptance
        busy_d = (state_d != RS_IDLE);
        done_d = (state_q == RS_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RS_IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RSHIFT_ARITH_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RSHIFT_ARITH_EN
            fill_q  <= fill_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rshift_seq.sv
// Self-checking bench for rshift_seq against a plain-arithmetic shift model.
module tb_rshift_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] in_v;
    logic [3:0]  amt;
    logic        arith;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int tests_run;
    int tests_failed;

    rshift_seq #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (in_v),
        .amt   (amt),
        .arith (arith),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] s, input logic ar);
        logic signed [15:0] sa;
        sa = a;
`ifdef RSHIFT_ARITH_EN
        if (ar) return 16'(sa >>> s);
`endif
        return a >> s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input string name, input logic [15:0] a, input logic [3:0] s,
                          input logic ar, input bit interfere);
        logic [15:0] exp;
        int          n;
        int          lat;
        exp = model(a, s, ar);
        n   = int'(s) / 4 + int'(s) % 4;
        start = 1'b1; in_v = a; amt = s; arith = ar;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; in_v = 16'($urandom); amt = 4'($urandom); arith = 1'($urandom);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s accept: busy=%b done=%b, expected busy=1 done=0", name, busy, done);
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (interfere && k == 1) begin
                start = 1'b1; in_v = 16'h0001; amt = 4'd1;
            end else if (interfere && k == 2) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        tests_run++;
        if (lat != n + 1) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d, expected %0d", name, lat, n + 1);
        end
        tests_run++;
        if (out !== exp) begin
            tests_failed++;
            $display("FAIL %s result: got %h, expected %h", name, out, exp);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy in done cycle: got %b, expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_v = '0; amt = '0; arith = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_out", 32'(out), 32'h0);
            chk("reset_busy", 32'(busy), 32'h0);
            chk("reset_done", 32'(done), 32'h0);
            start = 1'($urandom); in_v = 16'($urandom); amt = 4'($urandom);
        end
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_done", 32'(done), 32'h0);
            chk("post_reset_busy", 32'(busy), 32'h0);
            chk("post_reset_out", 32'(out), 32'h0);
        end
    endtask

    task automatic test_inverse_sweep();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 16'(i) << 12;
            run_op("sweep", v, 4'd12, 1'b0, 1'b0);
            chk("sweep_nibble", 32'(out), 32'(i));
            start = 1'b0;
            @(negedge clk);
            chk("sweep_single_done", 32'(done), 32'h0);
        end
    endtask

    task automatic test_zero_amount();
        run_op("zero_amt", 16'h1234, 4'd0, 1'b0, 1'b0);
        chk("zero_amt_out", 32'(out), 32'h1234);
        @(negedge clk);
        chk("zero_amt_retain", 32'(out), 32'h1234);
    endtask

    task automatic test_max_amount();
        run_op("max_amt", 16'h8000, 4'd15, 1'b1, 1'b0);
`ifdef RSHIFT_ARITH_EN
        chk("max_amt_const", 32'(out), 32'hFFFF);
`else
        chk("max_amt_const", 32'(out), 32'h0001);
`endif
        @(negedge clk);
    endtask

    task automatic test_busy_protection();
        run_op("busy_prot", 16'hFF00, 4'd8, 1'b0, 1'b1);
        chk("busy_prot_out", 32'(out), 32'h00FF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_prot_one_done", 32'(done), 32'h0);
            chk("busy_prot_idle", 32'(busy), 32'h0);
        end
        chk("busy_prot_retain", 32'(out), 32'h00FF);
    endtask

    task automatic test_abort();
        start = 1'b1; in_v = 16'hABCD; amt = 4'd15; arith = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("abort_out", 32'(out), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'h0);
        end
        run_op("after_abort", 16'hABCD, 4'd4, 1'b0, 1'b0);
        chk("after_abort_const", 32'(out), 32'h0ABC);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op("random", 16'($urandom), 4'($urandom), 1'($urandom), 1'b0);
            if (($urandom % 2) == 0) begin
                start = 1'b0;
                @(negedge clk);
                chk("random_single_done", 32'(done), 32'h0);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // Each op's start is raised in the previous done cycle.
        run_op("b2b_a", 16'hF0F0, 4'd5, 1'b1, 1'b0);
        run_op("b2b_b", 16'h8421, 4'd3, 1'b1, 1'b0);
        run_op("b2b_c", 16'h7FFF, 4'd0, 1'b0, 1'b0);
        run_op("b2b_d", 16'hC003, 4'd9, 1'b1, 1'b0);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_final_done", 32'(done), 32'h0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_inverse_sweep();
        test_zero_amount();
        test_max_amount();
        test_busy_protection();
        test_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
